// File: rtl/vga_sync_if.sv
// VGA raster timing bundle: pixel enable, counters, blanking, syncs, start pulses.
// master drives (vga_sync_gen), slave consumes (renderers, RGB mux).
interface vga_sync_if #(
    parameter int CNT_W = 10
);
    logic             pix_tick;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             vidon;
    logic             hsync;
    logic             vsync;
    logic             line_start;
    logic             frame_start;

    modport master (
        output pix_tick, hc, vc, vidon,
        output hsync, vsync, line_start, frame_start
    );

    modport slave (
        input pix_tick, hc, vc, vidon,
        input hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator (640x480@60 by default) from the system clock.
// Ports: clk, rst_n (async, active-low), vga (vga_sync_if.master, all registered).
module vga_sync_gen #(
    parameter int       CLK_DIV      = 4,
    parameter int       H_ACTIVE     = 640,
    parameter int       H_FP         = 16,
    parameter int       H_SYNC       = 96,
    parameter int       H_BP         = 48,
    parameter int       V_ACTIVE     = 480,
    parameter int       V_FP         = 10,
    parameter int       V_SYNC       = 2,
    parameter int       V_BP         = 33,
    parameter bit       SYNC_ACT_LOW = 1'b1,
    parameter int       CNT_W        = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_sync_if.master   vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Level driven on hsync/vsync while the sync window is active.
    localparam logic SYNC_ON  = ~SYNC_ACT_LOW;
    localparam logic SYNC_OFF = SYNC_ACT_LOW;

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_tick_q, pix_tick_d;
    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;
    logic             vidon_q, vidon_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             hs_act;
    logic             vs_act;

    always_comb begin
        div_d         = div_q;
        pix_tick_d    = 1'b0;
        hc_d          = hc_q;
        vc_d          = vc_q;
        hs_act        = 1'b0;
        vs_act        = 1'b0;
        vidon_d       = 1'b0;
        hsync_d       = SYNC_OFF;
        vsync_d       = SYNC_OFF;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d      = '0;
            pix_tick_d = 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end

        // Counters step on the edge that closes a pix_tick clock.
        if (pix_tick_q) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end

        // Decode from the next counter values so outputs line up with hc/vc.
        hs_act  = (hc_d >= HS_BEG) && (hc_d < HS_END);
        vs_act  = (vc_d >= VS_BEG) && (vc_d < VS_END);
        vidon_d = (hc_d < H_ACT_C) && (vc_d < V_ACT_C);
        hsync_d = hs_act ? SYNC_ON : SYNC_OFF;
        vsync_d = vs_act ? SYNC_ON : SYNC_OFF;

        // Only the first clock of a new pixel at column 0 pulses.
        line_start_d  = pix_tick_q && (hc_d == '0);
        frame_start_d = line_start_d && (vc_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pix_tick_q    <= 1'b0;
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            vidon_q       <= 1'b0;
            hsync_q       <= SYNC_OFF;
            vsync_q       <= SYNC_OFF;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_tick_q    <= pix_tick_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            vidon_q       <= vidon_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pix_tick    = pix_tick_q;
    assign vga.hc          = hc_q;
    assign vga.vc          = vc_q;
    assign vga.vidon       = vidon_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule
